mem_sp_arbiter: RTL



---
 rtl/mem_sp_arbiter_pkg.sv | 19 +
 rtl/mem_sp_arbiter_if.sv | 44 ++++
 rtl/mem_sp_arbiter_starve_cnt.sv | 39 +++
 rtl/mem_sp_arbiter.sv | 95 +++++++++
 4 files changed

// File: rtl/mem_sp_arbiter_pkg.sv
// Shared types and constants for the LSU/IF data-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LSU  = 2'd1,
        OWN_IF   = 2'd2
    } owner_t;

    localparam logic [63:0] SIM_PUTC_ADDR  = 64'h40;
    localparam logic [63:0] SIM_HALT_ADDR  = 64'h50;
    localparam logic [63:0] SIM_CYCLE_ADDR = 64'h60;

    // A limit of 0 still needs a 1-bit counter so the vector is never zero-width.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_sp_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave = arbiter, master = requesters/memory.
interface mem_sp_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = DATA_WIDTH,
    parameter int DATA_BYTES = DATA_WIDTH / 8
);
    logic                  i_lsu_req;
    logic [ADDR_WIDTH-1:0] i_lsu_addr;
    logic [DATA_WIDTH-1:0] i_lsu_wdata;
    logic [DATA_BYTES-1:0] i_lsu_wen;
    logic                  o_lsu_gnt;
    logic                  o_lsu_rvalid;
    logic [DATA_WIDTH-1:0] o_lsu_rdata;

    logic                  i_if_req;
    logic [ADDR_WIDTH-1:0] i_if_addr;
    logic                  o_if_gnt;
    logic                  o_if_rvalid;
    logic [DATA_WIDTH-1:0] o_if_rdata;

    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] o_mem_wdata;
    logic [DATA_BYTES-1:0] o_mem_wen;
    logic [DATA_WIDTH-1:0] i_mem_rdata;

    modport slave (
        input  i_lsu_req, i_lsu_addr, i_lsu_wdata, i_lsu_wen,
        output o_lsu_gnt, o_lsu_rvalid, o_lsu_rdata,
        input  i_if_req, i_if_addr,
        output o_if_gnt, o_if_rvalid, o_if_rdata,
        output o_mem_addr, o_mem_wdata, o_mem_wen,
        input  i_mem_rdata
    );

    modport master (
        output i_lsu_req, i_lsu_addr, i_lsu_wdata, i_lsu_wen,
        input  o_lsu_gnt, o_lsu_rvalid, o_lsu_rdata,
        output i_if_req, i_if_addr,
        input  o_if_gnt, o_if_rvalid, o_if_rdata,
        input  o_mem_addr, o_mem_wdata, o_mem_wen,
        output i_mem_rdata
    );

endinterface

// File: rtl/mem_sp_arbiter_starve_cnt.sv
// Counts consecutive denied IF cycles, saturating at STARVE_LIMIT; at_limit hands IF priority.
module mem_arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int CW = cnt_width(STARVE_LIMIT);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign at_limit = (STARVE_LIMIT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_sp_arbiter.sv
// Shares a single-port, one-cycle-latency data memory between LSU (priority) and IF.
//   state    | meaning
//   OWN_NONE | no access issued last cycle, no response due
//   OWN_LSU  | LSU access issued last cycle, memory data belongs to LSU
//   OWN_IF   | IF access issued last cycle, memory data belongs to IF
module mem_sp_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = DATA_WIDTH,
    parameter int DATA_BYTES   = DATA_WIDTH / 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_sp_arbiter_if.slave bus
);

    owner_t owner_q;
    owner_t owner_d;

    logic lsu_gnt;
    logic if_gnt;
    logic if_at_limit;
    logic starve_inc;
    logic starve_clr;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_BYTES-1:0] mem_wen;

    assign starve_inc = bus.i_if_req && !if_gnt;
    assign starve_clr = !bus.i_if_req || if_gnt;

    mem_arb_starve_cnt #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .at_limit (if_at_limit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Grants are gated by rst_n so nothing reaches memory while reset is asserted.
    always_comb begin
        lsu_gnt = 1'b0;
        if_gnt  = 1'b0;
        owner_d = OWN_NONE;
        if (rst_n) begin
            if (bus.i_if_req && (!bus.i_lsu_req || if_at_limit)) begin
                if_gnt = 1'b1;
            end else if (bus.i_lsu_req) begin
                lsu_gnt = 1'b1;
            end
        end
        if (lsu_gnt) begin
            owner_d = OWN_LSU;
        end else if (if_gnt) begin
            owner_d = OWN_IF;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wen   = '0;
        if (lsu_gnt) begin
            mem_addr  = bus.i_lsu_addr;
            mem_wdata = bus.i_lsu_wdata;
            mem_wen   = bus.i_lsu_wen;
        end else if (if_gnt) begin
            mem_addr  = bus.i_if_addr;
        end

        bus.o_lsu_gnt    = lsu_gnt;
        bus.o_if_gnt     = if_gnt;
        bus.o_mem_addr   = mem_addr;
        bus.o_mem_wdata  = mem_wdata;
        bus.o_mem_wen    = mem_wen;
        bus.o_lsu_rvalid = (owner_q == OWN_LSU);
        bus.o_if_rvalid  = (owner_q == OWN_IF);
        bus.o_lsu_rdata  = bus.i_mem_rdata;
        bus.o_if_rdata   = bus.i_mem_rdata;
    end

endmodule
